playback_controller: RTL and testbench

- Upstream stage of the flash music player.
- Decodes single-cycle ASCII key events into play/pause, direction and restart controls.
- Generates the per-sample strobe startsamplenow with a speed-adjustable period.
- Outputs drive the player's kybrd_forward, kybrd_pause and startsamplenow inputs, plus a restart pulse for the address controller.

---
 rtl/playback_pkg.sv | 20 ++
 rtl/playback_controller_sample_tick_gen.sv | 79 +++++++
 rtl/playback_controller.sv | 107 ++++++++++
 tb/tb_playback_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/playback_pkg.sv
// Shared types, key codes and divider helper for the playback controller.
package playback_pkg;

  typedef enum logic {
    PAUSED  = 1'b0,
    PLAYING = 1'b1
  } play_state_t;

  localparam logic [7:0] KEY_E = 8'h45;
  localparam logic [7:0] KEY_D = 8'h44;
  localparam logic [7:0] KEY_F = 8'h46;
  localparam logic [7:0] KEY_B = 8'h42;
  localparam logic [7:0] KEY_R = 8'h52;

  function automatic int unsigned div_nom(input int unsigned clk_freq,
                                          input int unsigned base_rate);
    return clk_freq / base_rate;
  endfunction

endpackage

// File: rtl/playback_controller_sample_tick_gen.sv
// Sample-rate divider register with clamped speed adjust, plus the tick
// counter that produces the one-cycle sample strobe.
module sample_tick_gen #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned DIV_NOM   = 2272,
  parameter int unsigned DIV_STEP  = 64,
  parameter int unsigned DIV_MIN   = 256,
  parameter int unsigned DIV_MAX   = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 clr,
  input  logic                 speed_up,
  input  logic                 speed_down,
  input  logic                 speed_rst,
  output logic                 strobe,
  output logic [DIV_WIDTH-1:0] divider
);

  localparam logic [DIV_WIDTH:0] STEP_X = (DIV_WIDTH+1)'(DIV_STEP);
  localparam logic [DIV_WIDTH:0] MIN_X  = (DIV_WIDTH+1)'(DIV_MIN);
  localparam logic [DIV_WIDTH:0] MAX_X  = (DIV_WIDTH+1)'(DIV_MAX);
  localparam logic [DIV_WIDTH:0] NOM_X  = (DIV_WIDTH+1)'(DIV_NOM);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH:0]   div_ext;
  logic [DIV_WIDTH:0]   count_ext;
  logic [DIV_WIDTH:0]   div_up;
  logic [DIV_WIDTH:0]   div_down;
  logic [DIV_WIDTH:0]   div_sum;
  logic [DIV_WIDTH:0]   div_next;
  logic                 term;

  always_comb begin
    div_ext   = {1'b0, div_q};
    count_ext = {1'b0, count_q};
    div_sum   = div_ext + STEP_X;

    // Compare before subtracting so the result can never wrap below zero.
    if (div_ext < MIN_X + STEP_X) div_up = MIN_X;
    else                          div_up = div_ext - STEP_X;

    if (div_sum > MAX_X) div_down = MAX_X;
    else                 div_down = div_sum;

    div_next = div_ext;
    if (speed_rst)                   div_next = NOM_X;
    else if (speed_up && !speed_down) div_next = div_up;
    else if (speed_down && !speed_up) div_next = div_down;

    term = (count_ext + 1'b1) >= div_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_WIDTH'(DIV_NOM);
    end else begin
      div_q <= div_next[DIV_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !run || clr) begin
      count_q <= '0;
      strobe  <= 1'b0;
    end else if (term) begin
      count_q <= '0;
      strobe  <= 1'b1;
    end else begin
      count_q <= count_q + 1'b1;
      strobe  <= 1'b0;
    end
  end

  assign divider = div_q;

endmodule

// File: rtl/playback_controller.sv
// Key-driven play/pause/direction/restart control and sample strobe for the
// flash music player. Build option: KEY_CASE_INSENSITIVE_EN accepts lowercase keys.
module playback_controller
  import playback_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BASE_RATE = 22000,
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned DIV_STEP  = 64,
  parameter int unsigned DIV_MIN   = 256,
  parameter int unsigned DIV_MAX   = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [7:0]           key_code,
  input  logic                 speed_up,
  input  logic                 speed_down,
  input  logic                 speed_rst,
  output logic                 kybrd_forward,
  output logic                 kybrd_pause,
  output logic                 restart,
  output logic                 startsamplenow,
  output logic [DIV_WIDTH-1:0] divider
);

  // state   | meaning
  // PAUSED  | no strobes, tick counter held at zero
  // PLAYING | tick counter running, strobe every divider cycles

  localparam int unsigned DIV_NOM = div_nom(CLK_FREQ, BASE_RATE);

  play_state_t state, state_next;
  logic        forward_q, forward_next;
  logic        pause_q;
  logic        restart_q, restart_next;
  logic        run;
  logic [7:0]  code;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
`ifdef KEY_CASE_INSENSITIVE_EN
    if (c >= 8'h61 && c <= 8'h7a) return c - 8'h20;
    else                          return c;
`else
    return c;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= PAUSED;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    forward_next = forward_q;
    restart_next = 1'b0;
    code         = fold_case(key_code);
    if (key_valid) begin
      case (code)
        KEY_E:   if (state == PAUSED)  state_next = PLAYING;
        KEY_D:   if (state == PLAYING) state_next = PAUSED;
        KEY_F:   forward_next = 1'b1;
        KEY_B:   forward_next = 1'b0;
        KEY_R:   restart_next = 1'b1;
        default: ;
      endcase
    end
    // A pause key on the terminal-count cycle must suppress that strobe.
    run = (state == PLAYING) && (state_next == PLAYING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      forward_q <= 1'b1;
      pause_q   <= 1'b1;
      restart_q <= 1'b0;
    end else begin
      forward_q <= forward_next;
      pause_q   <= (state_next == PAUSED);
      restart_q <= restart_next;
    end
  end

  sample_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_NOM   (DIV_NOM),
    .DIV_STEP  (DIV_STEP),
    .DIV_MIN   (DIV_MIN),
    .DIV_MAX   (DIV_MAX)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .clr        (restart_next),
    .speed_up   (speed_up),
    .speed_down (speed_down),
    .speed_rst  (speed_rst),
    .strobe     (startsamplenow),
    .divider    (divider)
  );

  assign kybrd_forward = forward_q;
  assign kybrd_pause   = pause_q;
  assign restart       = restart_q;

endmodule

// File: tb/tb_playback_controller.sv
// Directed self-checking bench for playback_controller.
module tb_playback_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        speed_up = 1'b0;
  logic        speed_down = 1'b0;
  logic        speed_rst = 1'b0;
  logic        kybrd_forward;
  logic        kybrd_pause;
  logic        restart;
  logic        startsamplenow;
  logic [15:0] divider;

  int checks = 0;
  int errors = 0;
  bit saw_strobe;

  always #5 clk = ~clk;

  playback_controller dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .speed_up       (speed_up),
    .speed_down     (speed_down),
    .speed_rst      (speed_rst),
    .kybrd_forward  (kybrd_forward),
    .kybrd_pause    (kybrd_pause),
    .restart        (restart),
    .startsamplenow (startsamplenow),
    .divider        (divider)
  );

  task automatic send_key(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic tick(input int k);
    saw_strobe = 1'b0;
    repeat (k) begin
      @(posedge clk); #1;
      if (startsamplenow) saw_strobe = 1'b1;
    end
  endtask

  // Edges until the next strobe; 70000 means the bound expired.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!startsamplenow && n < 70000);
  endtask

  task automatic pulse_speed(input bit up, input bit down, input bit rs);
    speed_up = up; speed_down = down; speed_rst = rs;
    @(posedge clk); #1;
    speed_up = 1'b0; speed_down = 1'b0; speed_rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (kybrd_pause !== 1'b1) begin errors++; $display("FAIL reset_pause got %0b want 1", kybrd_pause); end
    checks++; if (kybrd_forward !== 1'b1) begin errors++; $display("FAIL reset_forward got %0b want 1", kybrd_forward); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL reset_restart got %0b want 0", restart); end
    checks++; if (startsamplenow !== 1'b0) begin errors++; $display("FAIL reset_strobe got %0b want 0", startsamplenow); end
    checks++; if (divider !== 16'd2272) begin errors++; $display("FAIL reset_divider got %0d want 2272", divider); end
    rst = 1'b0;
  endtask

  task automatic test_play;
    int n;
    send_key(8'h45);
    checks++; if (kybrd_pause !== 1'b0) begin errors++; $display("FAIL play_pause got %0b want 0", kybrd_pause); end
    wait_strobe(n);
    checks++; if (n != 2272) begin errors++; $display("FAIL play_first_strobe got %0d want 2272", n); end
    wait_strobe(n);
    checks++; if (n != 2272) begin errors++; $display("FAIL play_period got %0d want 2272", n); end
  endtask

  task automatic test_pause_tc;
    int n;
    tick(2271);
    checks++; if (saw_strobe !== 1'b0) begin errors++; $display("FAIL pause_early_strobe got 1 want 0"); end
    send_key(8'h44);
    checks++; if (startsamplenow !== 1'b0) begin errors++; $display("FAIL pause_tc_strobe got %0b want 0", startsamplenow); end
    checks++; if (kybrd_pause !== 1'b1) begin errors++; $display("FAIL pause_tc_pause got %0b want 1", kybrd_pause); end
    checks++; if (dut.u_tick.count_q !== 16'd0) begin errors++; $display("FAIL pause_tc_count got %0d want 0", dut.u_tick.count_q); end
    tick(3000);
    checks++; if (saw_strobe !== 1'b0) begin errors++; $display("FAIL paused_strobe got 1 want 0"); end
    send_key(8'h45);
    wait_strobe(n);
    checks++; if (n != 2272) begin errors++; $display("FAIL resume_first_strobe got %0d want 2272", n); end
  endtask

  task automatic test_direction;
    int n;
    send_key(8'h42);
    checks++; if (kybrd_forward !== 1'b0) begin errors++; $display("FAIL dir_back got %0b want 0", kybrd_forward); end
    send_key(8'h46);
    checks++; if (kybrd_forward !== 1'b1) begin errors++; $display("FAIL dir_fwd got %0b want 1", kybrd_forward); end
    wait_strobe(n);
    checks++; if (n != 2270) begin errors++; $display("FAIL dir_period got %0d want 2270", n); end
    // Restart lands on the terminal-count cycle: it must swallow that strobe.
    tick(2271);
    send_key(8'h52);
    checks++; if (restart !== 1'b1) begin errors++; $display("FAIL restart_pulse got %0b want 1", restart); end
    checks++; if (startsamplenow !== 1'b0) begin errors++; $display("FAIL restart_strobe got %0b want 0", startsamplenow); end
    tick(1);
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_width got %0b want 0", restart); end
    wait_strobe(n);
    checks++; if (n + 1 != 2272) begin errors++; $display("FAIL restart_next_strobe got %0d want 2272", n + 1); end
    send_key(8'h44);
  endtask

  task automatic test_speed;
    int exp_div;
    exp_div = 2272;
    for (int i = 0; i < 40; i++) begin
      pulse_speed(1'b1, 1'b0, 1'b0);
      exp_div = exp_div - 64;
      if (exp_div < 256) exp_div = 256;
      checks++; if (divider !== 16'(exp_div)) begin errors++; $display("FAIL speed_up_%0d got %0d want %0d", i, divider, exp_div); end
    end
    repeat (1019) pulse_speed(1'b0, 1'b1, 1'b0);
    checks++; if (divider !== 16'd65472) begin errors++; $display("FAIL speed_down_near_max got %0d want 65472", divider); end
    pulse_speed(1'b0, 1'b1, 1'b0);
    checks++; if (divider !== 16'd65535) begin errors++; $display("FAIL speed_down_clamp got %0d want 65535", divider); end
    pulse_speed(1'b0, 1'b1, 1'b0);
    checks++; if (divider !== 16'd65535) begin errors++; $display("FAIL speed_down_hold got %0d want 65535", divider); end
    pulse_speed(1'b1, 1'b0, 1'b0);
    checks++; if (divider !== 16'd65471) begin errors++; $display("FAIL speed_up_from_max got %0d want 65471", divider); end
    pulse_speed(1'b1, 1'b1, 1'b0);
    checks++; if (divider !== 16'd65471) begin errors++; $display("FAIL speed_both got %0d want 65471", divider); end
    pulse_speed(1'b1, 1'b0, 1'b1);
    checks++; if (divider !== 16'd2272) begin errors++; $display("FAIL speed_rst got %0d want 2272", divider); end
  endtask

  task automatic test_cut;
    int n;
    send_key(8'h45);
    tick(240);
    // 32 back-to-back speed_up pulses take the divider 2272 -> 256 (clamped).
    saw_strobe = 1'b0;
    speed_up = 1'b1;
    repeat (32) begin
      @(posedge clk); #1;
      if (startsamplenow) saw_strobe = 1'b1;
    end
    speed_up = 1'b0;
    checks++; if (saw_strobe !== 1'b0) begin errors++; $display("FAIL cut_early_strobe got 1 want 0"); end
    checks++; if (divider !== 16'd256) begin errors++; $display("FAIL cut_divider got %0d want 256", divider); end
    @(posedge clk); #1;
    checks++; if (startsamplenow !== 1'b1) begin errors++; $display("FAIL cut_immediate_strobe got %0b want 1", startsamplenow); end
    wait_strobe(n);
    checks++; if (n != 256) begin errors++; $display("FAIL cut_period got %0d want 256", n); end
  endtask

  task automatic test_rst_mid;
    send_key(8'h42);
    pulse_speed(1'b0, 1'b1, 1'b0);
    tick(100);
    key_valid = 1'b1; key_code = 8'h52; rst = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 8'h00;
    checks++; if (kybrd_pause !== 1'b1) begin errors++; $display("FAIL rst_mid_pause got %0b want 1", kybrd_pause); end
    checks++; if (kybrd_forward !== 1'b1) begin errors++; $display("FAIL rst_mid_forward got %0b want 1", kybrd_forward); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL rst_mid_restart got %0b want 0", restart); end
    checks++; if (startsamplenow !== 1'b0) begin errors++; $display("FAIL rst_mid_strobe got %0b want 0", startsamplenow); end
    checks++; if (divider !== 16'd2272) begin errors++; $display("FAIL rst_mid_divider got %0d want 2272", divider); end
    rst = 1'b0;
    tick(1);
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL rst_mid_late_restart got %0b want 0", restart); end
  endtask

  task automatic test_case;
    logic exp_pause;
`ifdef KEY_CASE_INSENSITIVE_EN
    exp_pause = 1'b0;
`else
    exp_pause = 1'b1;
`endif
    send_key(8'h58);
    checks++; if (kybrd_pause !== 1'b1) begin errors++; $display("FAIL other_key_pause got %0b want 1", kybrd_pause); end
    send_key(8'h65);
    checks++; if (kybrd_pause !== exp_pause) begin errors++; $display("FAIL lowercase_e_pause got %0b want %0b", kybrd_pause, exp_pause); end
  endtask

  initial begin
    test_reset();
    test_play();
    test_pause_tc();
    test_direction();
    test_speed();
    test_cut();
    test_rst_mid();
    test_case();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
